// File: rtl/bicubic_pe_fork_join_if.sv
// Bundle for the bicubic processing-element fork/join block.
// Groups the request fork, the per-core request/response handshakes, the
// packed output stream and the status flags.
//   slave  : the fork/join block itself
//   master : the surrounding environment (request source, cores, sink)
interface bicubic_pe_fork_join_if #(
    parameter int unsigned NUM_CHANNELS  = 3,
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned TAPS          = 16,
    parameter int unsigned OUT_PIXELS    = 4
);
    localparam int unsigned IN_W  = TAPS * NUM_CHANNELS * CHANNEL_WIDTH;
    localparam int unsigned RSP_W = NUM_CHANNELS * OUT_PIXELS * CHANNEL_WIDTH;

    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_data;
    logic                    mono_en;
    logic [NUM_CHANNELS-1:0] ch_req_valid;
    logic [NUM_CHANNELS-1:0] ch_req_ready;
    logic [IN_W-1:0]         ch_req_data;
    logic [NUM_CHANNELS-1:0] ch_rsp_valid;
    logic [NUM_CHANNELS-1:0] ch_rsp_ready;
    logic [RSP_W-1:0]        ch_rsp_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [RSP_W-1:0]        out_data;
    logic                    frame_done;
    logic                    idle;

    modport slave (
        input  in_valid, in_data, mono_en, ch_req_ready, ch_rsp_valid, ch_rsp_data, out_ready,
        output in_ready, ch_req_valid, ch_req_data, ch_rsp_ready, out_valid, out_data,
               frame_done, idle
    );

    modport master (
        output in_valid, in_data, mono_en, ch_req_ready, ch_rsp_valid, ch_rsp_data, out_ready,
        input  in_ready, ch_req_valid, ch_req_data, ch_rsp_ready, out_valid, out_data,
               frame_done, idle
    );
endinterface

// File: rtl/bicubic_pe_fork_join.sv
// Fork/join glue between the neighbourhood buffer and the per-channel
// bicubic cores. One 4x4 request is registered and forked to every core
// (or core 0 only in mono mode); per-channel result FIFOs absorb cores that
// drift out of lockstep and the heads are packed into one output word.
// Output handshakes are counted per frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bicubic_pe_fork_join_if (request in, core
//                request/response handshakes, packed output, frame_done, idle)
module bicubic_pe_fork_join #(
    parameter int unsigned NUM_CHANNELS    = 3,
    parameter int unsigned CHANNEL_WIDTH   = 8,
    parameter int unsigned TAPS            = 16,
    parameter int unsigned OUT_PIXELS      = 4,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned WORDS_PER_FRAME = 518400
) (
    input logic                  clk,
    input logic                  rst_n,
    bicubic_pe_fork_join_if.slave bus
);
    localparam int unsigned NC      = NUM_CHANNELS;
    localparam int unsigned CW      = CHANNEL_WIDTH;
    localparam int unsigned IN_W    = TAPS * NC * CW;
    localparam int unsigned SLICE_W = OUT_PIXELS * CW;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [19:0] LAST_WORD = 20'(WORDS_PER_FRAME - 1);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t             state_q, state_d;
    logic [NC-1:0]      pending_q, req_hs, required;
    logic [IN_W-1:0]    req_data_q;
    logic               in_ready, accept;

    logic [SLICE_W-1:0] mem [NC][FIFO_DEPTH];
    logic [NC-1:0][AW:0] wr_ptr, rd_ptr;
    logic [NC-1:0]      empty, full, push, pop, rsp_ready;
    logic               out_valid, out_hs;
    logic [NC*SLICE_W-1:0] out_data;

    logic [19:0]        frame_cnt_q;
    logic               frame_done_q;
    logic               idle;

    // Mono mode only needs channel 0 forked and joined.
    assign required = bus.mono_en ? NC'(1) : '1;
    assign accept   = bus.in_valid & in_ready;
    assign req_hs   = pending_q & bus.ch_req_ready;

    // ---------------- fork FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: if ((pending_q & ~req_hs) == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        in_ready = rst_n && (state_q == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            req_data_q <= '0;
        end else if (accept) begin
            pending_q  <= required;
            req_data_q <= bus.in_data;
        end else begin
            pending_q  <= pending_q & ~req_hs;
        end
    end

    // ---------------- join FIFOs ----------------
    always_comb begin
        for (int unsigned c = 0; c < NC; c++) begin
            empty[c] = (wr_ptr[c] == rd_ptr[c]);
            full[c]  = (wr_ptr[c][AW] != rd_ptr[c][AW]) &&
                       (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
        end
    end

    assign out_valid = &(~empty | ~required);
    assign out_hs    = out_valid & bus.out_ready;
    assign pop       = required & {NC{out_hs}};
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign rsp_ready = ~full | pop;
    // Non-required channels (mono) never push, whatever their valid says.
    assign push      = bus.ch_rsp_valid & rsp_ready & required;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            for (int unsigned c = 0; c < NC; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + (AW+1)'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < NC; c++) begin
            if (push[c])
                mem[c][wr_ptr[c][AW-1:0]] <= bus.ch_rsp_data[(NC-1-c)*SLICE_W +: SLICE_W];
        end
    end

    // Repack channel-major FIFO heads into pixel-major output words.
    always_comb begin
        logic [SLICE_W-1:0] head;
        int unsigned        src;
        out_data = '0;
        head     = '0;
        src      = 0;
        if (out_valid) begin
            for (int unsigned c = 0; c < NC; c++) begin
                src  = bus.mono_en ? 0 : c;
                head = mem[src][rd_ptr[src][AW-1:0]];
                for (int unsigned p = 0; p < OUT_PIXELS; p++) begin
                    out_data[((OUT_PIXELS-1-p)*NC + (NC-1-c))*CW +: CW] =
                        head[(OUT_PIXELS-1-p)*CW +: CW];
                end
            end
        end
    end

    // ---------------- frame counting ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (out_hs) begin
                if (frame_cnt_q == LAST_WORD) begin
                    frame_cnt_q  <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    frame_cnt_q  <= frame_cnt_q + 20'd1;
                end
            end
        end
    end

    assign idle = (state_q == S_IDLE) && (&empty);

    assign bus.in_ready     = in_ready;
    assign bus.ch_req_valid = pending_q;
    assign bus.ch_req_data  = req_data_q;
    assign bus.ch_rsp_ready = rsp_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data;
    assign bus.frame_done   = frame_done_q;
    assign bus.idle         = idle;

    mono_stable_when_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !idle |-> $stable(bus.mono_en)
    ) else $error("mono_en changed while busy");
endmodule

// File: tb/tb_bicubic_pe_fork_join.sv
module tb_bicubic_pe_fork_join;
    localparam int NC = 3, CW = 8, TAPS = 16, OP = 4, FD = 4, WPF = 3;
    localparam int IW = TAPS * NC * CW;
    localparam int SW = OP * CW;
    localparam int OW = OP * NC * CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bicubic_pe_fork_join_if #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .TAPS(TAPS),
                              .OUT_PIXELS(OP)) bus ();

    bicubic_pe_fork_join #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .TAPS(TAPS),
                           .OUT_PIXELS(OP), .FIFO_DEPTH(FD), .WORDS_PER_FRAME(WPF))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] exp_q [$];
    logic [SW-1:0] core_q [NC][$];
    logic [7:0]    taps [TAPS][NC];

    int            ready_pct, rsp_pct, out_pct;
    logic [NC-1:0] force_low, rsp_hold, spurious;
    bit            mono_phase;
    int            mono_leak;

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each core returns, for pixel k, the byte sum of its
    // channel's 16 taps plus 0x10*(ch+1) plus k. Mono copies channel 0.
    function automatic logic [OW-1:0] ref_word(input bit mono);
        logic [OW-1:0] w;
        int sum [NC];
        int src;
        w = '0;
        for (int c = 0; c < NC; c++) begin
            sum[c] = 0;
            for (int t = 0; t < TAPS; t++) sum[c] += int'(taps[t][c]);
        end
        for (int p = 0; p < OP; p++)
            for (int c = 0; c < NC; c++) begin
                src = mono ? 0 : c;
                w[((OP-1-p)*NC + (NC-1-c))*CW +: CW] = 8'(sum[src] + 16*(src+1) + p);
            end
        return w;
    endfunction

    function automatic logic [IW-1:0] pack_taps();
        logic [IW-1:0] d;
        d = '0;
        for (int t = 0; t < TAPS; t++)
            for (int c = 0; c < NC; c++)
                d[((TAPS-1-t)*NC + (NC-1-c))*CW +: CW] = taps[t][c];
        return d;
    endfunction

    function automatic logic [SW-1:0] core_result(input int c, input logic [IW-1:0] d);
        logic [SW-1:0] r;
        int sum;
        sum = 0;
        for (int t = 0; t < TAPS; t++) sum += int'(d[((TAPS-1-t)*NC + (NC-1-c))*CW +: CW]);
        for (int p = 0; p < OP; p++) r[(OP-1-p)*CW +: CW] = 8'(sum + 16*(c+1) + p);
        return r;
    endfunction

    task automatic set_taps(input bit rnd);
        for (int t = 0; t < TAPS; t++)
            for (int c = 0; c < NC; c++) taps[t][c] = rnd ? 8'($urandom) : 8'h00;
    endtask

    function automatic bit cores_empty();
        for (int c = 0; c < NC; c++) if (core_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit mono);
        logic [OW-1:0] e;
        int n;
        e = ref_word(mono);
        bus.in_data  = pack_taps();
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", IW'(bus.in_ready), IW'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = bus.idle && (exp_q.size() == 0) && cores_empty();
        end
        chk("drain", IW'(done), IW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   IW'(bus.in_ready),     IW'(0));
        chk({tag, "_idle"},       IW'(bus.idle),         IW'(1));
        chk({tag, "_out_valid"},  IW'(bus.out_valid),    IW'(0));
        chk({tag, "_rsp_ready"},  IW'(bus.ch_rsp_ready), IW'(3'b111));
        chk({tag, "_req_valid"},  IW'(bus.ch_req_valid), IW'(0));
        chk({tag, "_frame_done"}, IW'(bus.frame_done),   IW'(0));
        chk({tag, "_out_data"},   IW'(bus.out_data),     IW'(0));
        chk({tag, "_req_data"},   bus.ch_req_data,       IW'(0));
    endtask

    // Core models and output sink: sample handshakes at negedge, update at posedge+1.
    initial begin : core_drv
        logic [NC-1:0]    rq_hs, rs_hs, rdy, vld;
        logic [IW-1:0]    rq_d;
        logic [NC*SW-1:0] rd;
        bus.ch_req_ready = '0;
        bus.ch_rsp_valid = '0;
        bus.ch_rsp_data  = '0;
        bus.out_ready    = 1'b0;
        forever begin
            @(negedge clk);
            rq_hs = bus.ch_req_valid & bus.ch_req_ready;
            rs_hs = bus.ch_rsp_valid & bus.ch_rsp_ready;
            rq_d  = bus.ch_req_data;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                for (int c = 0; c < NC; c++) core_q[c].delete();
                bus.ch_req_ready = '0;
                bus.ch_rsp_valid = '0;
                bus.ch_rsp_data  = '0;
                bus.out_ready    = 1'b0;
            end else begin
                rd = '0;
                for (int c = 0; c < NC; c++) begin
                    if (rq_hs[c]) core_q[c].push_back(core_result(c, rq_d));
                    if (rs_hs[c] && !spurious[c] && core_q[c].size() > 0) void'(core_q[c].pop_front());
                    rdy[c] = !force_low[c] && ($urandom_range(0, 99) < ready_pct);
                    vld[c] = 1'b0;
                    if (spurious[c]) begin
                        vld[c] = 1'b1;
                        rd[(NC-1-c)*SW +: SW] = SW'($urandom);
                    end else if (core_q[c].size() > 0 && !rsp_hold[c] &&
                                 $urandom_range(0, 99) < rsp_pct) begin
                        vld[c] = 1'b1;
                        rd[(NC-1-c)*SW +: SW] = core_q[c][0];
                    end
                end
                bus.ch_req_ready = rdy;
                bus.ch_rsp_valid = vld;
                bus.ch_rsp_data  = rd;
                bus.out_ready    = ($urandom_range(0, 99) < out_pct);
            end
        end
    end

    // Scoreboard monitor: output words and frame_done timing.
    initial begin : monitor
        int fcnt;
        bit fd_exp;
        fcnt = 0;
        fd_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                fcnt = 0;
                fd_exp = 1'b0;
            end else begin
                chk("frame_done", IW'(bus.frame_done), IW'(fd_exp));
                fd_exp = 1'b0;
                if (mono_phase && bus.ch_req_valid[NC-1:1] != '0) mono_leak++;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got %0h want none", bus.out_data);
                    end else begin
                        chk("out_word", IW'(bus.out_data), IW'(exp_q.pop_front()));
                    end
                    fcnt++;
                    if (fcnt == WPF) begin
                        fcnt = 0;
                        fd_exp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mono_en  = 1'b0;
        ready_pct = 100; rsp_pct = 100; out_pct = 100;
        force_low = '0; rsp_hold = '0; spurious = '0;
        mono_phase = 1'b0; mono_leak = 0;

        // reset state
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", IW'(bus.in_ready), IW'(1));

        // single request, all cores ready
        set_taps(1'b0);
        send(1'b0);
        chk("single_in_ready_busy", IW'(bus.in_ready), IW'(0));
        chk("single_req_valid", IW'(bus.ch_req_valid), IW'(3'b111));
        @(negedge clk);
        chk("single_in_ready_back", IW'(bus.in_ready), IW'(1));
        drain(200);

        // core 2 stalls its request
        force_low = 3'b100;
        @(negedge clk);
        set_taps(1'b1);
        send(1'b0);
        chk("stall_first_valid", IW'(bus.ch_req_valid), IW'(3'b111));
        @(negedge clk);
        chk("stall_partial_valid", IW'(bus.ch_req_valid), IW'(3'b100));
        chk("stall_in_ready", IW'(bus.in_ready), IW'(0));
        repeat (3) @(negedge clk);
        chk("stall_still_valid", IW'(bus.ch_req_valid), IW'(3'b100));
        chk("stall_req_data_hold", bus.ch_req_data, pack_taps());
        force_low = '0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_release", IW'(bus.in_ready), IW'(1));
        drain(200);

        // core 0 responses held back while core 1/2 run ahead
        rsp_hold = 3'b001;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_taps(1'b1);
            send(1'b0);
        end
        repeat (8) @(negedge clk);
        chk("skew_no_out_valid", IW'(bus.out_valid), IW'(0));
        chk("skew_rsp_ready", IW'(bus.ch_rsp_ready), IW'(3'b111));
        rsp_hold = '0;
        drain(300);

        // output back-pressure fills every FIFO
        out_pct = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            set_taps(1'b1);
            send(1'b0);
        end
        repeat (10) @(negedge clk);
        chk("full_rsp_ready", IW'(bus.ch_rsp_ready), IW'(0));
        chk("full_out_valid", IW'(bus.out_valid), IW'(1));
        out_pct = 100;
        drain(300);

        // mono mode, channels 1/2 assert junk responses that must be ignored
        bus.mono_en = 1'b1;
        spurious = 3'b110;
        mono_phase = 1'b1;
        @(negedge clk);
        set_taps(1'b0);
        taps[0][0] = 8'h9B;
        send(1'b1);
        ready_pct = 70; rsp_pct = 60; out_pct = 70;
        for (int i = 0; i < 8; i++) begin
            set_taps(1'b1);
            send(1'b1);
        end
        drain(500);
        spurious = '0;
        repeat (3) @(negedge clk);
        mono_phase = 1'b0;
        bus.mono_en = 1'b0;
        @(negedge clk);
        chk("mono_no_req_other", IW'(mono_leak), IW'(0));

        // random traffic with cores drifting
        ready_pct = 60; rsp_pct = 50; out_pct = 60;
        for (int i = 0; i < 40; i++) begin
            set_taps(1'b1);
            send(1'b0);
        end
        drain(3000);

        // reset mid-frame with work in flight
        ready_pct = 100; rsp_pct = 100; out_pct = 0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            set_taps(1'b1);
            send(1'b0);
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_pct = 100;
        @(negedge clk);
        chk("midreset_idle_after", IW'(bus.idle), IW'(1));
        for (int i = 0; i < 3; i++) begin
            set_taps(1'b1);
            send(1'b0);
        end
        drain(300);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
